tt_um_mod6_checker: RTL
=======================

Name: tt_um_mod6_checker

Overview:
- Receive-side companion to the mod-6 counter tile: samples a 3-bit count presented on ui_in when a strobe rises and checks that successive samples follow the sequence 0,1,2,3,4,5,0,…
- Reports the next expected value, lock status, error pulse and sticky flags on uo_out.
- Drives a saturating 8-bit error count on uio_out.
- Standard TinyTapeout user-tile wrapper; the strobe and data inputs are asynchronous to clk.

Parameters:
- MODULUS, 6: sequence length; legal values are 0..MODULUS-1; width fixed at 3 bits.
- LOCK_COUNT, 4: consecutive in-sequence samples required to assert locked; range 2..7.
- SYNC_STAGES, 2: synchroniser depth on ui_in[4:0]; minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tile enable; when low, all state holds and strobes are ignored.
- ui_in  in  8  [2:0] observed count; [3] sample strobe; [4] clear; [7:5] unused.
- uio_in  in  8  unused.
- uo_out  out  8  [2:0] expected next value; [3] locked; [4] err_pulse; [5] err_sticky; [6] illegal_sticky; [7] heartbeat (toggles per accepted sample).
- uio_out  out  8  error count, saturating at 255.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, prev=0, streak=0, err_cnt=0, all flags 0, heartbeat 0.
  - Synchroniser flops also clear, so no strobe edge is detected on the first cycles after reset.
- Synchronisation: ui_in[4:0] passes through SYNC_STAGES flops plus one edge-detect flop on strobe.
  - A sample event is the synchronised strobe's 0→1 transition.
  - Data must be stable from SYNC_STAGES+1 cycles before the strobe rises until the strobe falls.
- Latency: strobe first sampled high at edge E0 → all outputs updated at edge E0+SYNC_STAGES.
  - err_pulse is high for exactly one cycle, the cycle that follows that edge.
- expected = (prev+1) mod MODULUS in TRACK/LOCK; 0 in IDLE.
- States:
  - IDLE:
    - Sample v < MODULUS → TRACK, prev=v, streak=1.
    - Sample v ≥ MODULUS → error, illegal_sticky=1, stay IDLE.
  - TRACK:
    - v == expected → prev=v, streak=streak+1. When streak reaches LOCK_COUNT → LOCK.
    - v legal but ≠ expected → error, resync: prev=v, streak=1, stay TRACK.
    - v illegal → error, illegal_sticky=1, → IDLE, streak=0.
  - LOCK:
    - v == expected → prev=v, stay LOCK; streak saturates at LOCK_COUNT.
    - Mismatch or illegal → same as TRACK, and locked deasserts at the same edge.
- Any error: err_pulse=1 for one cycle, err_sticky=1, err_cnt=min(err_cnt+1, 255).
- Wrap-around: prev=MODULUS-1 expects 0. A sample of 0 is in-sequence; a sample of MODULUS is illegal.
- Every processed sample toggles heartbeat, including erroneous ones.
- Clear (synchronised ui_in[4] high, level): same values as reset, applied synchronously while high.
  - If clear and a sample event occur in the same cycle, clear wins and the sample is discarded.
- ena low:
  - The synchroniser keeps running.
  - Sample events and clear are discarded.
  - Outputs hold.
- Reset mid-sequence: outputs immediately return to reset values; no residual error pulse.

Optional Feature:
- Macro MOD6_CHK_HOLD_EN.
  - Defined: in TRACK/LOCK, a sample equal to prev is legal and represents a paused counter. It toggles heartbeat and does not change prev, streak, state or error outputs.
  - Undefined: a repeated value is a legal mismatch and is handled as an error with resync.

Test Plan:
- Reset, then samples 0,1,2,3 → locked rises at the edge processing "3"; expected=4; err_cnt=0; heartbeat toggled 4 times.
- Locked at prev=5, then samples 0,1 → no error across the wrap; expected=2; locked stays 1.
- Locked at prev=2, then sample 4 → err_pulse for one cycle; err_sticky=1; err_cnt=1; locked=0; expected=5; streak=1; 3 more good samples relock.
- Sample 7 from TRACK → illegal_sticky=1; state IDLE; expected=0; err_cnt+1.
  - Then assert clear together with a strobe edge → all outputs return to reset values; the sample is ignored.
- 300 illegal samples → uio_out saturates at 8'hFF and stays there; uio_oe=8'hFF throughout.
- Sample 3 then 3 → without MOD6_CHK_HOLD_EN, err_cnt=1; with it, err_cnt=0, heartbeat toggles and expected stays 4.
  - Also: ena low during a strobe → no state change.

Source files
------------

// File: rtl/tt_um_mod6_checker.sv
// rtl/tt_um_mod6_checker.sv - mod-6 sequence checker tile; optional MOD6_CHK_HOLD_EN accepts repeated values as pauses
module tt_um_mod6_checker #(
    parameter int MODULUS     = 6,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam logic [2:0] MOD_M1 = 3'(MODULUS - 1);
    localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]                  sync_last;
    logic                        strobe_d;

    state_t     state;
    logic [2:0] prev;
    logic [2:0] streak;
    logic [7:0] err_cnt;
    logic       err_pulse;
    logic       err_sticky;
    logic       illegal_sticky;
    logic       heartbeat;

    logic       sample_event;
    logic       clr;
    logic [2:0] v;
    logic [2:0] expected_next;
    logic [2:0] exp_val;
    logic       is_illegal;
    logic       in_seq;
    logic       is_hold;
    logic       is_err;

    // Input synchroniser for data, strobe and clear; runs even when ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            strobe_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ui_in[4:0]};
            strobe_d <= sync_q[SYNC_STAGES-1][3];
        end
    end

    assign sync_last    = sync_q[SYNC_STAGES-1];
    assign sample_event = sync_last[3] & ~strobe_d;
    assign clr          = sync_last[4];
    assign v            = sync_last[2:0];

    // Classify the synchronised sample against the current tracking state
    always_comb begin
        expected_next = (prev == MOD_M1) ? 3'd0 : prev + 3'd1;
        exp_val       = (state == IDLE) ? 3'd0 : expected_next;
        is_illegal    = (v > MOD_M1);
        in_seq        = (state != IDLE) && (v == expected_next);
`ifdef MOD6_CHK_HOLD_EN
        is_hold       = (state != IDLE) && (v == prev) && !is_illegal;
`else
        is_hold       = 1'b0;
`endif
        is_err        = is_illegal || ((state != IDLE) && !in_seq && !is_hold);
    end

    // Sequence tracker: state, streak, error flags, error counter and heartbeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            prev           <= 3'd0;
            streak         <= 3'd0;
            err_cnt        <= 8'd0;
            err_pulse      <= 1'b0;
            err_sticky     <= 1'b0;
            illegal_sticky <= 1'b0;
            heartbeat      <= 1'b0;
        end else if (ena) begin
            err_pulse <= 1'b0;
            if (clr) begin
                state          <= IDLE;
                prev           <= 3'd0;
                streak         <= 3'd0;
                err_cnt        <= 8'd0;
                err_sticky     <= 1'b0;
                illegal_sticky <= 1'b0;
                heartbeat      <= 1'b0;
            end else if (sample_event) begin
                heartbeat <= ~heartbeat;
                if (is_err) begin
                    err_pulse  <= 1'b1;
                    err_sticky <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                if (is_illegal) begin
                    illegal_sticky <= 1'b1;
                    state          <= IDLE;
                    streak         <= 3'd0;
                end else if (state == IDLE) begin
                    state  <= TRACK;
                    prev   <= v;
                    streak <= 3'd1;
                end else if (in_seq) begin
                    prev <= v;
                    if (streak >= LOCK_N - 3'd1) begin
                        state  <= LOCK;
                        streak <= LOCK_N;
                    end else begin
                        streak <= streak + 3'd1;
                    end
                end else if (!is_hold) begin
                    // Legal but out of sequence: resynchronise on the new value
                    state  <= TRACK;
                    prev   <= v;
                    streak <= 3'd1;
                end
            end
        end
    end

    assign uo_out  = {heartbeat, illegal_sticky, err_sticky, err_pulse,
                      (state == LOCK), exp_val};
    assign uio_out = err_cnt;
    assign uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in, ui_in[7:5]};

endmodule
